// File: rtl/bp_types_pkg.sv
// Shared types for the OTTER dynamic branch predictor: predictor mode,
// default BTB geometry and the BTB entry layout for that geometry.
package bp_types;

    localparam int BP_ENTRIES_DEF = 16;
    localparam int BP_TAG_W_DEF   = 8;
    localparam int BP_CTR_W_DEF   = 2;

    typedef enum logic {
        BP_STATIC  = 1'b0,
        BP_BIMODAL = 1'b1
    } bp_mode_t;

    // The top re-declares this layout with its own TAG_W/CTR_W so non-default builds size correctly
    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_DEF-1:0] tag;
        logic [31:0]             target;
        logic [BP_CTR_W_DEF-1:0] ctr;
    } btb_entry_t;

    function automatic logic [31:0] bp_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter next-value logic used on the BTB update path.
// Init loads the weakly-taken value (MSB set, all other bits clear).
module bp_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_init,
    output logic [CTR_W-1:0] o_ctr
);

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));

    always_comb begin
        o_ctr = i_ctr;
        if (i_init) begin
            o_ctr = CTR_WEAK;
        end else if (i_inc && (i_ctr != CTR_MAX)) begin
            o_ctr = i_ctr + CTR_W'(1);
        end else if (i_dec && (i_ctr != '0)) begin
            o_ctr = i_ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with saturating counters: zero-latency fetch lookup,
// execute-stage mispredict detection and training, plus statistics counters.
module otter_branch_predictor
    import bp_types::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int MODE    = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    input  logic        i_if_valid,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_is_ctrl,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_lookup_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam bit BIMODAL = (MODE == int'(BP_BIMODAL));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t           r_btb [ENTRIES];
    logic [31:0]      r_lookup_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [TAG_W-1:0] w_ex_tag;
    entry_t           w_if_entry;
    entry_t           w_ex_entry;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_ex_taken;
    logic             w_train;
    logic [CTR_W-1:0] w_next_ctr;

    assign w_if_idx   = i_if_pc[IDX_W+1:2];
    assign w_if_tag   = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_idx   = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag   = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_if_entry = r_btb[w_if_idx];
    assign w_ex_entry = r_btb[w_ex_idx];
    assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

    // Lookup reads the pre-update table contents; there is no write bypass
    assign o_pred_taken  = BIMODAL && w_if_hit && w_if_entry.ctr[CTR_W-1];
    assign o_pred_target = o_pred_taken ? w_if_entry.target : bp_next_seq(i_if_pc);

    // A non-control instruction never counts as taken, so an alias hit redirects to PC+4
    assign w_ex_taken    = i_ex_is_ctrl && i_ex_taken;
    assign o_mispredict  = i_ex_valid && ((w_ex_taken != i_ex_pred_taken) ||
                           (w_ex_taken && (i_ex_target != i_ex_pred_target)));
    assign o_redirect_pc = w_ex_taken ? i_ex_target : bp_next_seq(i_ex_pc);

    assign w_train = BIMODAL && i_ex_valid;

    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .i_ctr  (w_ex_entry.ctr),
        .i_inc  (w_ex_hit && w_ex_taken),
        .i_dec  (w_ex_hit && !w_ex_taken),
        .i_init (!w_ex_hit && w_ex_taken),
        .o_ctr  (w_next_ctr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].ctr   <= '0;
            end
        end else if (w_train) begin
            if (i_ex_is_ctrl) begin
                // A taken miss allocates; a hit in either direction updates in place
                if (w_ex_hit || w_ex_taken) begin
                    r_btb[w_ex_idx].valid <= 1'b1;
                    r_btb[w_ex_idx].tag   <= w_ex_tag;
                    r_btb[w_ex_idx].ctr   <= w_next_ctr;
                    if (w_ex_taken) begin
                        r_btb[w_ex_idx].target <= i_ex_target;
                    end
                end
            end else if (w_ex_hit) begin
                r_btb[w_ex_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lookup_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (i_if_valid) begin
                r_lookup_cnt <= r_lookup_cnt + 32'd1;
            end
            if (o_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_lookup_cnt  = r_lookup_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Self-checking bench: bimodal and static predictor builds driven in parallel
// and compared every cycle against a table model, plus hand-computed checkpoints.
module tb_otter_branch_predictor;

    localparam int NENT    = 16;
    localparam int CTR_TOP = 3;
    localparam int CTR_INI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ifPc;
    logic        ifValid;
    logic        exValid;
    logic [31:0] exPc;
    logic        exIsCtrl;
    logic        exTaken;
    logic [31:0] exTarget;
    logic        exPredTaken;
    logic [31:0] exPredTarget;

    logic        predTaken1, mispredict1;
    logic [31:0] predTarget1, redirect1, lookupCnt1, mispredCnt1;
    logic        predTaken0, mispredict0;
    logic [31:0] predTarget0, redirect0, lookupCnt0, mispredCnt0;

    int asserts  = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    bit          mValid  [NENT];
    int          mTag    [NENT];
    logic [31:0] mTarget [NENT];
    int          mCtr    [NENT];
    int unsigned mLookups = 0;
    int unsigned mMispreds = 0;

    logic        expTaken, expMis, takenEff;
    logic [31:0] expTarget, expRedir;

    logic [31:0] pcList  [6] = '{32'h100, 32'h140, 32'h104, 32'h1100, 32'h300, 32'h3FC};
    logic [31:0] tgtList [4] = '{32'h80, 32'h400, 32'h104, 32'h2000};

    otter_branch_predictor #(.ENTRIES(16), .TAG_W(8), .CTR_W(2), .MODE(1)) dutBimodal (
        .i_clk(clk), .i_reset(reset), .i_if_pc(ifPc), .i_if_valid(ifValid),
        .o_pred_taken(predTaken1), .o_pred_target(predTarget1),
        .i_ex_valid(exValid), .i_ex_pc(exPc), .i_ex_is_ctrl(exIsCtrl), .i_ex_taken(exTaken),
        .i_ex_target(exTarget), .i_ex_pred_taken(exPredTaken), .i_ex_pred_target(exPredTarget),
        .o_mispredict(mispredict1), .o_redirect_pc(redirect1),
        .o_lookup_cnt(lookupCnt1), .o_mispred_cnt(mispredCnt1)
    );

    otter_branch_predictor #(.ENTRIES(16), .TAG_W(8), .CTR_W(2), .MODE(0)) dutStatic (
        .i_clk(clk), .i_reset(reset), .i_if_pc(ifPc), .i_if_valid(ifValid),
        .o_pred_taken(predTaken0), .o_pred_target(predTarget0),
        .i_ex_valid(exValid), .i_ex_pc(exPc), .i_ex_is_ctrl(exIsCtrl), .i_ex_taken(exTaken),
        .i_ex_target(exTarget), .i_ex_pred_taken(exPredTaken), .i_ex_pred_target(exPredTarget),
        .o_mispredict(mispredict0), .o_redirect_pc(redirect0),
        .o_lookup_cnt(lookupCnt0), .o_mispred_cnt(mispredCnt0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ifv, input logic [31:0] ifp,
                                 input bit exv, input logic [31:0] exp, input bit ctrl,
                                 input bit tkn, input logic [31:0] tgt,
                                 input bit ptk, input logic [31:0] ptg);
        @(negedge clk);
        reset = rst; ifValid = ifv; ifPc = ifp;
        exValid = exv; exPc = exp; exIsCtrl = ctrl; exTaken = tkn; exTarget = tgt;
        exPredTaken = ptk; exPredTarget = ptg;
        #3;
    endtask

    function automatic int pcIdx(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int pcTag(input logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    // Model of what the table predicts and how one cycle changes it
    task automatic modelLookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = pcIdx(pc);
        tk = mValid[i] && (mTag[i] == pcTag(pc)) && (mCtr[i] >= CTR_INI);
        tg = tk ? mTarget[i] : pc + 32'd4;
    endtask

    task automatic modelUpdate();
        int  i;
        bit  hit;
        if (reset) begin
            for (int k = 0; k < NENT; k++) begin
                mValid[k] = 1'b0;
                mCtr[k]   = 0;
            end
            mLookups  = 0;
            mMispreds = 0;
            return;
        end
        if (ifValid) mLookups++;
        if (expMis)  mMispreds++;
        if (!exValid) return;
        i   = pcIdx(exPc);
        hit = mValid[i] && (mTag[i] == pcTag(exPc));
        if (exIsCtrl) begin
            if (hit && exTaken) begin
                mCtr[i]    = (mCtr[i] < CTR_TOP) ? mCtr[i] + 1 : CTR_TOP;
                mTarget[i] = exTarget;
            end else if (hit) begin
                mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
            end else if (exTaken) begin
                mValid[i]  = 1'b1;
                mTag[i]    = pcTag(exPc);
                mTarget[i] = exTarget;
                mCtr[i]    = CTR_INI;
            end
        end else if (hit) begin
            mValid[i] = 1'b0;
        end
    endtask

    // Compare both builds against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        #2;
        modelLookup(ifPc, expTaken, expTarget);
        takenEff = exIsCtrl && exTaken;
        expMis   = exValid && ((takenEff != exPredTaken) || (takenEff && exTarget != exPredTarget));
        expRedir = takenEff ? exTarget : exPc + 32'd4;
        if (checkEn) begin
            checkOutput("bim_pred_taken", {31'd0, predTaken1}, {31'd0, expTaken});
            checkOutput("bim_pred_target", predTarget1, expTarget);
            checkOutput("bim_mispredict", {31'd0, mispredict1}, {31'd0, expMis});
            checkOutput("bim_redirect", redirect1, expRedir);
            checkOutput("bim_lookup_cnt", lookupCnt1, mLookups);
            checkOutput("bim_mispred_cnt", mispredCnt1, mMispreds);
            checkOutput("sta_pred_taken", {31'd0, predTaken0}, 32'd0);
            checkOutput("sta_pred_target", predTarget0, ifPc + 32'd4);
            checkOutput("sta_mispredict", {31'd0, mispredict0}, {31'd0, expMis});
            checkOutput("sta_redirect", redirect0, expRedir);
            checkOutput("sta_lookup_cnt", lookupCnt0, mLookups);
            checkOutput("sta_mispred_cnt", mispredCnt0, mMispreds);
        end
        modelUpdate();
    end

    initial begin
        reset = 1'b1; ifValid = 1'b0; ifPc = '0; exValid = 1'b0; exPc = '0;
        exIsCtrl = 1'b0; exTaken = 1'b0; exTarget = '0; exPredTaken = 1'b0; exPredTarget = '0;

        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkEn = 1'b1;
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

        applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_reset_pred_taken", {31'd0, predTaken1}, 32'd0);
        checkOutput("lit_reset_pred_target", predTarget1, 32'h104);
        checkOutput("lit_reset_lookup_cnt", lookupCnt1, 32'd0);
        applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_lookup_cnt_1", lookupCnt1, 32'd1);

        // Taken BEQ 0x100 -> 0x80 predicted not-taken; lookup same cycle still sees old entry
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        checkOutput("lit_beq_mispredict", {31'd0, mispredict1}, 32'd1);
        checkOutput("lit_beq_redirect", redirect1, 32'h80);
        checkOutput("lit_same_cycle_old", {31'd0, predTaken1}, 32'd0);
        applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_alloc_pred_taken", {31'd0, predTaken1}, 32'd1);
        checkOutput("lit_alloc_pred_target", predTarget1, 32'h80);
        checkOutput("lit_mispred_cnt_1", mispredCnt1, 32'd1);
        checkOutput("lit_static_untrained", {31'd0, predTaken0}, 32'd0);

        // Not-taken three times: 2 -> 1 -> 0 -> 0
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 0, 32'h104, 1, 32'h80);
        checkOutput("lit_nt1_mispredict", {31'd0, mispredict1}, 32'd1);
        checkOutput("lit_nt1_redirect", redirect1, 32'h104);
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 0, 32'h104, 0, 32'h104);
        checkOutput("lit_nt2_pred_taken", {31'd0, predTaken1}, 32'd0);
        checkOutput("lit_nt2_mispredict", {31'd0, mispredict1}, 32'd0);
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 0, 32'h104, 0, 32'h104);
        checkOutput("lit_nt3_mispredict", {31'd0, mispredict1}, 32'd0);
        checkOutput("lit_mispred_cnt_2", mispredCnt1, 32'd2);
        // Counter floored at 0, so one taken brings it only to 1 (still not-taken)
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        checkOutput("lit_floor_pred_taken", {31'd0, predTaken1}, 32'd0);

        // Alias: non-control instruction hitting the entry with a taken prediction
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80);
        checkOutput("lit_alias_pre_taken", {31'd0, predTaken1}, 32'd1);
        checkOutput("lit_alias_mispredict", {31'd0, mispredict1}, 32'd1);
        checkOutput("lit_alias_redirect", redirect1, 32'h104);
        applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        checkOutput("lit_alias_invalidated", {31'd0, predTaken1}, 32'd0);
        applyStimulus(0, 1, 32'h140, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_tag_miss_taken", {31'd0, predTaken1}, 32'd0);
        checkOutput("lit_tag_miss_target", predTarget1, 32'h144);
        applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_realloc_taken", {31'd0, predTaken1}, 32'd1);
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_pc_wrap", predTarget1, 32'h0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), pcList[$urandom_range(0, 5)],
                          1'($urandom_range(0, 3) != 0), pcList[$urandom_range(0, 5)],
                          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                          tgtList[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                          tgtList[$urandom_range(0, 3)]);
        end

        // Reset wins over a same-cycle taken training write
        applyStimulus(1, 1, 32'h300, 1, 32'h300, 1, 1, 32'h40, 0, 32'h304);
        checkOutput("lit_rst_mispredict", {31'd0, mispredict1}, 32'd1);
        checkOutput("lit_rst_redirect", redirect1, 32'h40);
        applyStimulus(0, 1, 32'h300, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_rst_no_alloc", {31'd0, predTaken1}, 32'd0);
        checkOutput("lit_rst_target", predTarget1, 32'h304);
        checkOutput("lit_rst_lookup_cnt", lookupCnt1, 32'd0);
        checkOutput("lit_rst_mispred_cnt", mispredCnt1, 32'd0);
        applyStimulus(0, 0, 32'h300, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("lit_post_rst_lookup", lookupCnt1, 32'd1);

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
